// File: rtl/router_ctrl_fsm.sv
// Router input-side control FSM: decodes the header, steers bytes to one of three FIFOs,
// checks parity/length. Optional idle-FIFO flush timeout is enabled by SOFT_RESET_TIMEOUT_EN.
module router_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       busy,
    output logic       err,
    output logic [2:0] soft_reset
);

    localparam logic [2:0] StDecodeAddress    = 3'd0;
    localparam logic [2:0] StWaitTillEmpty    = 3'd1;
    localparam logic [2:0] StLoadFirstData    = 3'd2;
    localparam logic [2:0] StLoadData         = 3'd3;
    localparam logic [2:0] StFifoFullState    = 3'd4;
    localparam logic [2:0] StLoadAfterFull    = 3'd5;
    localparam logic [2:0] StCheckParityError = 3'd6;

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q;
    logic [7:0] acc_q, parity_q;
    logic [5:0] len_q, cnt_q;
    logic       err_q;
    logic       busy_c, wr_c;

    // Pad to four entries so address 3 indexes a defined zero rather than out of range.
    logic [3:0] empty_pad, full_pad, srst_pad, addr_hot;
    logic       sel_empty, sel_full, sel_srst, hdr_empty, hdr_ok, take_byte;

    assign empty_pad = {1'b0, fifo_empty};
    assign full_pad  = {1'b0, fifo_full};
    assign srst_pad  = {1'b0, soft_reset};
    assign addr_hot  = 4'b0001 << addr_q;
    assign sel_empty = empty_pad[addr_q];
    assign sel_full  = full_pad[addr_q];
    assign sel_srst  = srst_pad[addr_q];
    assign hdr_empty = empty_pad[data_in[1:0]];
    assign hdr_ok    = pkt_valid && (data_in[1:0] != 2'd3);
    assign take_byte = ((state_q == StLoadData) && !sel_full) || (state_q == StLoadAfterFull);

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        wr_c    = 1'b0;
        case (state_q)
            StDecodeAddress: begin
                if (hdr_ok) begin
                    busy_c  = 1'b1;
                    state_d = hdr_empty ? StLoadFirstData : StWaitTillEmpty;
                end
            end
            StWaitTillEmpty: begin
                busy_c = 1'b1;
                if (sel_srst) begin
                    state_d = StDecodeAddress;
                end else if (sel_empty) begin
                    state_d = StLoadFirstData;
                end
            end
            StLoadFirstData: begin
                wr_c    = 1'b1;
                state_d = StLoadData;
            end
            StLoadData: begin
                busy_c = sel_full;
                if (sel_full) begin
                    state_d = StFifoFullState;
                end else begin
                    wr_c = 1'b1;
                    if (!pkt_valid) state_d = StCheckParityError;
                end
            end
            StFifoFullState: begin
                busy_c = 1'b1;
                if (sel_srst) begin
                    state_d = StDecodeAddress;
                end else if (!sel_full) begin
                    state_d = StLoadAfterFull;
                end
            end
            StLoadAfterFull: begin
                wr_c    = 1'b1;
                state_d = pkt_valid ? StLoadData : StCheckParityError;
            end
            StCheckParityError: begin
                busy_c  = 1'b1;
                state_d = StDecodeAddress;
            end
            default: state_d = StDecodeAddress;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StDecodeAddress;
            addr_q   <= 2'd0;
            acc_q    <= 8'd0;
            parity_q <= 8'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == StDecodeAddress) && hdr_ok) addr_q <= data_in[1:0];
            if (state_q == StLoadFirstData) begin
                acc_q <= data_in;
                len_q <= data_in[7:2];
                cnt_q <= 6'd0;
                err_q <= 1'b0;
            end
            // A byte taken with pkt_valid low is the parity byte, not payload.
            if (take_byte) begin
                if (pkt_valid) begin
                    acc_q <= acc_q ^ data_in;
                    cnt_q <= cnt_q + 6'd1;
                end else begin
                    parity_q <= data_in;
                end
            end
            if (state_q == StCheckParityError) begin
                err_q <= (acc_q != parity_q) || (cnt_q != len_q);
            end
        end
    end

    // Reset must silence busy even while a header sits on data_in.
    assign busy      = busy_c && resetn;
    assign write_enb = wr_c ? addr_hot[2:0] : 3'b000;
    assign lfd_state = (state_q == StLoadFirstData);
    assign ld_state  = (state_q == StLoadData);
    assign laf_state = (state_q == StLoadAfterFull);
    assign err       = err_q;

`ifdef SOFT_RESET_TIMEOUT_EN
    localparam logic [4:0] TimeoutMax = 5'(TIMEOUT - 1);

    logic [2:0][4:0] idle_cnt_q;
    logic [2:0]      soft_reset_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt_q   <= '0;
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    idle_cnt_q[i]   <= 5'd0;
                    soft_reset_q[i] <= 1'b0;
                end else if (idle_cnt_q[i] == TimeoutMax) begin
                    idle_cnt_q[i]   <= 5'd0;
                    soft_reset_q[i] <= 1'b1;
                end else begin
                    idle_cnt_q[i]   <= idle_cnt_q[i] + 5'd1;
                    soft_reset_q[i] <= 1'b0;
                end
            end
        end
    end

    assign soft_reset = soft_reset_q;
`else
    localparam int unsigned UnusedTimeout = TIMEOUT;
    logic unused_read_enb;
    assign unused_read_enb = ^read_enb;
    assign soft_reset      = 3'b000;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: a source model honouring busy, a write scoreboard,
// and immediate-assertion checks on flags, err and soft_reset.
module tb_router_ctrl_fsm;

    logic       clk;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic [2:0] write_enb;
    logic       lfd_state, ld_state, laf_state, busy, err;
    logic [2:0] soft_reset;

    int checks   = 0;
    int failures = 0;
    int n_writes = 0;
    int lfd_seen = 0;
    int laf_seen = 0;

    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [2:0]  cur_we;

`ifdef SOFT_RESET_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    router_ctrl_fsm #(.TIMEOUT(30)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .ld_state   (ld_state),
        .laf_state  (laf_state),
        .busy       (busy),
        .err        (err),
        .soft_reset (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {write_enb, byte}.
    always @(negedge clk) begin
        if (lfd_state) lfd_seen++;
        if (laf_state) laf_seen++;
        if (write_enb !== 3'b000) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_write: observed we=%b data=%h expected no write",
                       write_enb, data_in);
            end else begin
                exp_item = exp_q.pop_front();
                assert ({write_enb, data_in} === exp_item) else begin
                    failures++;
                    $error("FAIL write_data: observed we=%b data=%h expected we=%b data=%h",
                           write_enb, data_in, exp_item[10:8], exp_item[7:0]);
                end
            end
        end
    end

    // Present a byte and hold it until a cycle with busy low consumes it.
    task automatic send_byte(input logic v, input logic [7:0] b);
        int n;
        n = 0;
        pkt_valid = v;
        data_in   = b;
        @(negedge clk);
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            failures++;
            $error("FAIL busy_timeout: observed busy=1 after 50 cycles expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic v, input logic [7:0] b);
        exp_q.push_back({cur_we, b});
        send_byte(v, b);
    endtask

    int base_w, base_l, base_a;

    initial begin
        resetn     = 1'b0;
        pkt_valid  = 1'b1;
        data_in    = 8'h0D;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        cur_we     = 3'b000;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(write_enb), 0);
        check("rst_flags", 32'({lfd_state, ld_state, laf_state}), 0);
        check("rst_err", 32'(err), 0);
        check("rst_srst", 32'(soft_reset), 0);
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Good packet to FIFO1
        cur_we = 3'b010; base_w = n_writes; base_l = lfd_seen;
        xfer(1'b1, 8'h0D); xfer(1'b1, 8'h11); xfer(1'b1, 8'h22); xfer(1'b1, 8'h33);
        xfer(1'b0, 8'h0D);
        send_byte(1'b0, 8'h00);
        check("p1_writes", 32'(n_writes - base_w), 5);
        check("p1_lfd", 32'(lfd_seen - base_l), 1);
        check("p1_err", 32'(err), 0);

        // FIFO1 full for two cycles mid-payload
        base_w = n_writes; base_a = laf_seen;
        xfer(1'b1, 8'h0D); xfer(1'b1, 8'h11);
        exp_q.push_back({cur_we, 8'h22});
        pkt_valid = 1'b1; data_in = 8'h22; fifo_full = 3'b010;
        @(negedge clk);
        check("full_ld_busy", 32'({busy, ld_state}), 32'b11);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_state_busy", 32'({busy, ld_state, laf_state}), 32'b100);
        @(posedge clk); #1;
        fifo_full = 3'b000;
        @(negedge clk);
        check("full_release_busy", 32'(busy), 1);
        send_byte(1'b1, 8'h22);
        xfer(1'b1, 8'h33); xfer(1'b0, 8'h0D);
        send_byte(1'b0, 8'h00);
        check("full_writes", 32'(n_writes - base_w), 5);
        check("full_laf", 32'(laf_seen - base_a), 1);
        check("full_err", 32'(err), 0);

        // Bad parity
        xfer(1'b1, 8'h0D); xfer(1'b1, 8'h11); xfer(1'b1, 8'h22); xfer(1'b1, 8'h33);
        xfer(1'b0, 8'h00);
        send_byte(1'b0, 8'h00);
        check("parity_err", 32'(err), 1);

        // FIFO2 not empty at header: wait, err still held
        cur_we = 3'b100;
        exp_q.push_back({cur_we, 8'h0A});
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 8'h0A;
        @(negedge clk);
        check("wait_decode_busy", 32'(busy), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_state", 32'({busy, write_enb, lfd_state}), 32'b1_000_0);
            @(posedge clk); #1;
        end
        check("err_hold", 32'(err), 1);
        fifo_empty = 3'b111; base_l = lfd_seen;
        send_byte(1'b1, 8'h0A);
        check("wait_lfd", 32'(lfd_seen - base_l), 1);
        check("err_cleared", 32'(err), 0);
        xfer(1'b1, 8'h01); xfer(1'b1, 8'h02); xfer(1'b0, 8'h09);
        send_byte(1'b0, 8'h00);
        check("p2_err", 32'(err), 0);

        // Length mismatch: header says 1 payload byte, 2 sent, parity correct
        cur_we = 3'b010;
        xfer(1'b1, 8'h05); xfer(1'b1, 8'h11); xfer(1'b1, 8'h22); xfer(1'b0, 8'h36);
        send_byte(1'b0, 8'h00);
        check("len_err", 32'(err), 1);

        // Address 3 header is ignored
        pkt_valid = 1'b1; data_in = 8'h0F;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("addr3_idle", 32'({busy, write_enb, lfd_state}), 0);
            @(posedge clk); #1;
        end
        check("addr3_err_hold", 32'(err), 1);

        // Reset during LOAD_DATA
        cur_we = 3'b001;
        xfer(1'b1, 8'h0C); xfer(1'b1, 8'h11);
        pkt_valid = 1'b1; data_in = 8'h22;
        #1;
        check("pre_rst_ld", 32'(ld_state), 1);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_outputs",
              32'({write_enb, busy, lfd_state, ld_state, laf_state, err, soft_reset}), 0);
        pkt_valid = 1'b0; data_in = 8'h00;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("post_rst_flags", 32'({lfd_state, ld_state, laf_state, busy}), 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        // Idle FIFO0 with data and no reads
        fifo_empty = 3'b110; read_enb = 3'b000;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            check("timeout_pulse", 32'(soft_reset),
                  (TimeoutEn && k == 30) ? 32'b001 : 32'b000);
        end
        fifo_empty = 3'b111;
        @(posedge clk); #1;
        fifo_empty = 3'b110;
        for (int k = 1; k <= 35; k++) begin
            read_enb = (k == 29) ? 3'b001 : 3'b000;
            @(posedge clk); #1;
            check("timeout_read", 32'(soft_reset), 0);
        end
        read_enb = 3'b000; fifo_empty = 3'b111;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_ctrl_fsm.md
ROUTER_CTRL_FSM -- requirements
Module: router_ctrl_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, idle cycles before soft reset of an unread FIFO.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pkt_valid  input  1  high during header and payload bytes; low on the parity byte.
REQ-005 SHALL have port data_in  input  8  source byte; header = {length[7:2], addr[1:0]}.
REQ-006 SHALL have ports fifo_full, fifo_empty, read_enb  input  3 each  per-output-FIFO status and reader strobes.
REQ-007 SHALL have port write_enb  output  3  one-hot write strobe to the FIFO at the latched address.
REQ-008 SHALL have ports lfd_state, ld_state, laf_state  output  1 each  decoded state flags (load-first-data, load-data, load-after-full).
REQ-009 SHALL have port busy  output  1  source must hold data_in next cycle when high.
REQ-010 SHALL have port err  output  1  parity or length mismatch of the last packet.
REQ-011 SHALL have port soft_reset  output  3  one-cycle per-FIFO flush pulse.

Function
REQ-012 States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR; moore flags lfd/ld/laf high only in their state.
REQ-013 DECODE_ADDRESS: pkt_valid and addr!=3 -> latch addr, busy=1; next LOAD_FIRST_DATA if fifo_empty[addr], else WAIT_TILL_EMPTY; addr==3 -> byte ignored, stay, busy=0.
REQ-014 WAIT_TILL_EMPTY: busy=1, no write; -> LOAD_FIRST_DATA when fifo_empty[addr].
REQ-015 LOAD_FIRST_DATA: write_enb[addr]=1 (header), busy=0, parity accumulator := data_in, length := data_in[7:2], payload count := 0; -> LOAD_DATA.
REQ-016 LOAD_DATA: busy=fifo_full[addr] (combinational); full -> FIFO_FULL_STATE with no write, regardless of pkt_valid.
REQ-017 LOAD_DATA not full, pkt_valid=1: write, XOR byte into accumulator, count+1 (6-bit, wraps mod 64), stay.
REQ-018 LOAD_DATA not full, pkt_valid=0: write parity byte, -> CHECK_PARITY_ERROR.
REQ-019 FIFO_FULL_STATE: busy=1, no write; -> LOAD_AFTER_FULL when fifo_full[addr]=0.
REQ-020 LOAD_AFTER_FULL: write held byte, busy=0; pkt_valid=1 -> accumulate, count+1, LOAD_DATA; pkt_valid=0 -> treat as parity byte, CHECK_PARITY_ERROR.
REQ-021 CHECK_PARITY_ERROR: busy=1, one cycle; err registered := (accumulator!=parity byte) OR (count!=length); -> DECODE_ADDRESS.
REQ-022 err SHALL hold until the next accepted header clears it in LOAD_FIRST_DATA.
REQ-023 write_enb SHALL be zero for non-latched addresses and in all non-writing states.
REQ-024 soft_reset[addr] asserted while in WAIT_TILL_EMPTY or FIFO_FULL_STATE SHALL abandon the packet -> DECODE_ADDRESS next cycle, no write.

Reset
REQ-025 resetn low SHALL immediately force DECODE_ADDRESS; write_enb=0, lfd/ld/laf=0, busy=0, err=0, soft_reset=0, counters/accumulator=0.
REQ-026 Reset mid-packet SHALL discard the packet; no write after resetn rises until a new header.

Configuration
REQ-027 Macro SOFT_RESET_TIMEOUT_EN defined: per FIFO i, 5-bit counter increments each cycle with fifo_empty[i]=0 and read_enb[i]=0, clears on read_enb[i] or fifo_empty[i]; on reaching TIMEOUT-1 it pulses soft_reset[i] for one cycle and clears.
REQ-028 Macro undefined: soft_reset SHALL be constant 0, no timeout counters, REQ-024 unreachable.

Verification
REQ-029 Header 0x0D (addr 1, len 3), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D, FIFO1 empty -> 5 writes on write_enb=3'b010, lfd one cycle, err=0.
REQ-030 Same packet with parity 0x00 -> err=1 after CHECK_PARITY_ERROR; next header clears err.
REQ-031 fifo_full[1] asserted 2 cycles mid-payload -> busy=1, no write, FIFO_FULL_STATE then LOAD_AFTER_FULL writes held byte; total writes still 5.
REQ-032 fifo_empty[2]=0 at header 0x0A -> WAIT_TILL_EMPTY with busy=1 until empty, then lfd.
REQ-033 With SOFT_RESET_TIMEOUT_EN, fifo_empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0] one-cycle pulse on cycle 30; read_enb[0] at cycle 29 -> no pulse.
REQ-034 Header addr 3 (0x0F) -> no write, busy=0; resetn low during LOAD_DATA -> all outputs 0 same cycle.
